// File: rtl/bpsk_frame_check.sv
// rtl/bpsk_frame_check.sv - BPSK receiver frame parser with CRC-8 check and FWFT output buffer
module bpsk_frame_check #(
    parameter int          MAX_LEN    = 255,
    parameter logic [7:0]  CRC_POLY   = 8'h07,
    parameter logic [7:0]  CRC_INIT   = 8'h00,
    parameter int          OBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_push,
    input  logic        in_sync,
    input  logic        in_last,
    output logic        in_stop,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_first,
    output logic        out_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [1:0]  err_code,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);
    localparam int          PW        = $clog2(OBUF_DEPTH);
    localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [PW:0] FULL_LVL  = (PW+1)'(OBUF_DEPTH);
    localparam logic [PW:0] STOP_LVL  = (PW+1)'(OBUF_DEPTH - 2);

    // The LEN byte is handled on the sync byte itself, so no separate LEN state is held.
    typedef enum logic [1:0] {S_IDLE, S_PAY, S_CRC, S_HUNT} state_t;

    function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ CRC_POLY) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [7:0]    crc_q, crc_d;
    logic [7:0]    rem_q, rem_d;
    logic          first_q, first_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          in_stop_q, in_stop_d;
    logic          done_q, done_d, ok_q, ok_d;
    logic [1:0]    code_q, code_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
    logic          push, pop, push_last;

    logic [7:0]    mem_data  [OBUF_DEPTH];
    logic          mem_first [OBUF_DEPTH];
    logic          mem_last  [OBUF_DEPTH];

    // Frame parsing, status decision and output-buffer bookkeeping for the next cycle.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        rem_d     = rem_q;
        first_d   = first_q;
        done_d    = 1'b0;
        ok_d      = 1'b0;
        code_d    = 2'd0;
        push      = 1'b0;
        push_last = 1'b0;
        pop       = (cnt_q != '0) && out_ready;

        if (in_push) begin
            if (in_sync) begin
                // A sync inside a running frame aborts it; the byte still starts a new frame.
                if (state_q == S_PAY || state_q == S_CRC) begin
                    done_d = 1'b1;
                    code_d = 2'd3;
                end
                crc_d   = crc8_next(CRC_INIT, in_byte);
                rem_d   = in_byte;
                first_d = 1'b1;
                if ({1'b0, in_byte} > MAX_LEN_W) begin
                    if (!done_d) begin
                        done_d = 1'b1;
                        code_d = 2'd2;
                    end
                    state_d = S_HUNT;
                end else if (in_last) begin
                    if (!done_d) begin
                        done_d = 1'b1;
                        code_d = 2'd2;
                    end
                    state_d = S_IDLE;
                end else if (in_byte == 8'd0) begin
                    state_d = S_CRC;
                end else begin
                    state_d = S_PAY;
                end
            end else begin
                case (state_q)
                    S_PAY: begin
                        if (cnt_q == FULL_LVL) begin
                            // Overflow: byte dropped, frame abandoned.
                            done_d  = 1'b1;
                            code_d  = 2'd3;
                            state_d = S_HUNT;
                        end else begin
                            push      = 1'b1;
                            push_last = (rem_q == 8'd1);
                            first_d   = 1'b0;
                            crc_d     = crc8_next(crc_q, in_byte);
                            rem_d     = rem_q - 8'd1;
                            if (in_last) begin
                                done_d  = 1'b1;
                                code_d  = 2'd2;
                                state_d = S_IDLE;
                            end else if (rem_q == 8'd1) begin
                                state_d = S_CRC;
                            end
                        end
                    end
                    S_CRC: begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        if (!in_last) begin
                            code_d = 2'd2;
                        end else if (in_byte == crc_q) begin
                            ok_d = 1'b1;
                        end else begin
                            code_d = 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        in_stop_d   = (cnt_d >= STOP_LVL);
        frame_cnt_d = frame_cnt_q + 16'(done_d & ok_d);
        err_cnt_d   = err_cnt_q + 16'(done_d & ~ok_d);
    end

    // State, status and counter registers; reset discards any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            crc_q       <= CRC_INIT;
            rem_q       <= 8'd0;
            first_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            in_stop_q   <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            code_q      <= 2'd0;
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            in_stop_q   <= in_stop_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            code_q      <= code_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Output buffer storage; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q]  <= in_byte;
            mem_first[wr_ptr_q] <= first_q;
            mem_last[wr_ptr_q]  <= push_last;
        end
    end

    assign out_valid  = (cnt_q != '0);
    assign out_data   = out_valid ? mem_data[rd_ptr_q]  : 8'd0;
    assign out_first  = out_valid ? mem_first[rd_ptr_q] : 1'b0;
    assign out_last   = out_valid ? mem_last[rd_ptr_q]  : 1'b0;
    assign in_stop    = in_stop_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;
    assign err_code   = code_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_bpsk_frame_check.sv
// tb/tb_bpsk_frame_check.sv - self-checking bench for bpsk_frame_check
module tb_bpsk_frame_check;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_byte = 8'd0;
    logic        in_push = 1'b0, in_sync = 1'b0, in_last = 1'b0;
    logic        in_stop;
    logic [7:0]  out_data;
    logic        out_valid, out_first, out_last;
    logic        out_ready;
    logic        frame_done, frame_ok;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt, err_cnt;

    logic dir_ready = 1'b1;
    logic rnd_ready = 1'b1;
    logic rand_mode = 1'b0;
    assign out_ready = rand_mode ? rnd_ready : dir_ready;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_fcnt = 0;
    int exp_ecnt = 0;
    logic [9:0] exp_out[$];   // {first, last, data}
    int         exp_res[$];   // 0 = good, else expected err_code

    bpsk_frame_check dut (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_push(in_push), .in_sync(in_sync),
        .in_last(in_last), .in_stop(in_stop), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
        .frame_done(frame_done), .frame_ok(frame_ok), .err_code(err_code),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #2 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC-8 of a message, MSB-first, polynomial 0x07, init 0x00.
    function automatic logic [7:0] crc8(input logic [7:0] msg[$]);
        logic [7:0] c;
        c = 8'h00;
        foreach (msg[i]) begin
            c = c ^ msg[i];
            repeat (8) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Scoreboard: every transfer and every frame status is matched to the model queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                chk("out_expected", exp_out.size() != 0, 1);
                if (exp_out.size() != 0) begin
                    logic [9:0] e;
                    e = exp_out.pop_front();
                    chk("out_data", out_data, e[7:0]);
                    chk("out_first", out_first, e[9]);
                    chk("out_last", out_last, e[8]);
                end
            end
            if (frame_done) begin
                chk("done_expected", exp_res.size() != 0, 1);
                if (exp_res.size() != 0) begin
                    int r;
                    r = exp_res.pop_front();
                    chk("frame_ok", frame_ok, r == 0);
                    if (r != 0) chk("err_code", err_code, r);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic s, input logic l,
                        input bit honor, input int gapmax);
        int w;
        repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
        if (honor) begin
            w = 0;
            while (in_stop && w < 200) begin @(posedge clk); #1; w++; end
            chk("stop_wait_bound", w < 200, 1);
        end
        in_byte = b; in_sync = s; in_last = l; in_push = 1'b1;
        @(posedge clk); #1;
        in_push = 1'b0; in_sync = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] pay[$],
                              input logic [7:0] cx, input int gapmax);
        logic [7:0] msg[$];
        logic [7:0] c;
        msg.push_back(len);
        foreach (pay[i]) msg.push_back(pay[i]);
        c = crc8(msg) ^ cx;
        foreach (pay[i]) exp_out.push_back({i == 0, i == int'(len) - 1, pay[i]});
        exp_res.push_back(cx == 0 ? 0 : 1);
        if (cx == 0) exp_fcnt++; else exp_ecnt++;
        send(len, 1, 0, 1, gapmax);
        foreach (pay[i]) send(pay[i], 0, 0, 1, gapmax);
        send(c, 0, 1, 1, gapmax);
    endtask

    task automatic drain_and_count(input string tag);
        int w;
        w = 0;
        while ((exp_out.size() != 0 || exp_res.size() != 0) && w < 500) begin
            @(posedge clk); #1; w++;
        end
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "_pending"}, exp_out.size() + exp_res.size(), 0);
        chk({tag, "_frame_cnt"}, frame_cnt, exp_fcnt);
        chk({tag, "_err_cnt"}, err_cnt, exp_ecnt);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_first"}, out_first, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_in_stop"}, in_stop, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_ok"}, frame_ok, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        logic [7:0] p[$];
        logic [7:0] m[$];
        logic [7:0] c;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_outputs("reset");

        // Empty frame, good CRC, then bad CRC.
        p = {};
        send_frame(8'h00, p, 8'h00, 0);
        drain_and_count("t1");
        send_frame(8'h00, p, 8'h5A, 0);
        drain_and_count("t2");

        // Three-byte payload with good CRC.
        p = {8'h11, 8'h22, 8'h33};
        send_frame(8'h03, p, 8'h00, 0);
        drain_and_count("t3");

        // in_last before the CRC slot.
        exp_out.push_back({1'b1, 1'b0, 8'hAA});
        exp_out.push_back({1'b0, 1'b0, 8'hBB});
        exp_res.push_back(2); exp_ecnt++;
        send(8'h04, 1, 0, 1, 0);
        send(8'hAA, 0, 0, 1, 0);
        send(8'hBB, 0, 1, 1, 0);
        drain_and_count("t4a");

        // CRC slot reached without in_last.
        exp_out.push_back({1'b1, 1'b1, 8'h77});
        exp_res.push_back(2); exp_ecnt++;
        send(8'h01, 1, 0, 1, 0);
        send(8'h77, 0, 0, 1, 0);
        send(8'h00, 0, 0, 1, 0);
        drain_and_count("t4b");

        // Sync at second payload byte aborts and starts a new frame.
        exp_out.push_back({1'b1, 1'b0, 8'h01});
        exp_res.push_back(3); exp_ecnt++;
        send(8'h05, 1, 0, 1, 0);
        send(8'h01, 0, 0, 1, 0);
        m = {8'h03, 8'h44, 8'h55, 8'h66};
        c = crc8(m);
        exp_out.push_back({1'b1, 1'b0, 8'h44});
        exp_out.push_back({1'b0, 1'b0, 8'h55});
        exp_out.push_back({1'b0, 1'b1, 8'h66});
        exp_res.push_back(0); exp_fcnt++;
        send(8'h03, 1, 0, 1, 0);
        send(8'h44, 0, 0, 1, 0);
        send(8'h55, 0, 0, 1, 0);
        send(8'h66, 0, 0, 1, 0);
        send(c, 0, 1, 1, 0);
        drain_and_count("t4c");

        // Backpressure honoured: no loss.
        m = {8'h08};
        for (int i = 0; i < 8; i++) begin
            m.push_back(8'(8'hC0 + i));
            exp_out.push_back({i == 0, i == 7, 8'(8'hC0 + i)});
        end
        exp_res.push_back(0); exp_fcnt++;
        dir_ready = 1'b0;
        send(8'h08, 1, 0, 0, 0);
        send(m[1], 0, 0, 0, 0);
        chk("stop_low_at_1", in_stop, 0);
        send(m[2], 0, 0, 0, 0);
        chk("stop_high_at_2", in_stop, 1);
        dir_ready = 1'b1;
        for (int i = 3; i <= 8; i++) send(m[i], 0, 0, 1, 0);
        send(crc8(m), 0, 1, 1, 0);
        drain_and_count("t5a");

        // Backpressure ignored: fifth payload byte overflows.
        dir_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_out.push_back({i == 0, 1'b0, 8'(8'hD0 + i)});
        exp_res.push_back(3); exp_ecnt++;
        send(8'h08, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) send(8'(8'hD0 + i), 0, 0, 0, 0);
        chk("stop_when_full", in_stop, 1);
        chk("valid_when_full", out_valid, 1);
        dir_ready = 1'b1;
        drain_and_count("t5b");

        // Unsynced bytes are ignored; reset mid-frame leaves nothing behind.
        for (int i = 0; i < 4; i++) send(8'($urandom), 0, 0, 1, 0);
        dir_ready = 1'b0;
        send(8'h03, 1, 0, 1, 0);
        send(8'h11, 0, 0, 1, 0);
        chk("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_fcnt = 0; exp_ecnt = 0;
        chk_reset_outputs("midreset");
        dir_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("midreset_no_done", frame_cnt + err_cnt, 0);

        // Random frames with random consumer stalls and gaps.
        rand_mode = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int len;
            logic [7:0] cx;
            len = $urandom_range(0, 12);
            p = {};
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(8'(len), p, cx, 2);
        end
        rand_mode = 1'b0;
        dir_ready = 1'b1;
        drain_and_count("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
